// File: rtl/stateful_array_atom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stateful_array_atom                                                      |
// | DEPTH-entry conditional add/subtract state array, two-stage RMW pipeline |
// | with same-index forwarding and optional signed/saturating arithmetic.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module stateful_array_atom #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 16,
   parameter int IDX_W    = $clog2(DEPTH),
   parameter bit SIGNED   = 1'b0,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [IDX_W-1:0] in_idx,
   input  logic [WIDTH-1:0] pkt_1,
   input  logic [WIDTH-1:0] pkt_2,
   input  logic [WIDTH-1:0] cons_1,
   input  logic [WIDTH-1:0] cons_2,
   input  logic [WIDTH-1:0] cons_3,
   input  logic [WIDTH-1:0] cons_4,
   input  logic [WIDTH-1:0] cons_5,
   input  logic             sel_1,
   input  logic             sel_3,
   input  logic             sel_5,
   input  logic [1:0]       sel_2,
   input  logic [1:0]       sel_4,
   input  logic [1:0]       sel_6,
   input  logic [1:0]       sel_7,
   input  logic [1:0]       sel_8,
   input  logic [1:0]       rel_opcode,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx,
   output logic [WIDTH-1:0] o__read,
   output logic [WIDTH-1:0] o__write
);

   localparam int             c_EXT_W  = WIDTH + 2;
   localparam logic [IDX_W:0] c_DEPTH  = (IDX_W + 1)'(DEPTH);
   localparam logic [WIDTH-1:0] c_ZERO = '0;

   logic [WIDTH-1:0]   r_mem [DEPTH];

   logic               r_s1_valid;
   logic               r_s1_in_range;
   logic [IDX_W-1:0]   r_s1_idx;
   logic [WIDTH-1:0]   r_s1_st;
   logic [WIDTH-1:0]   r_s1_pkt_1;
   logic [WIDTH-1:0]   r_s1_pkt_2;
   logic [WIDTH-1:0]   r_s1_cons_1;
   logic [WIDTH-1:0]   r_s1_cons_2;
   logic [WIDTH-1:0]   r_s1_cons_3;
   logic [WIDTH-1:0]   r_s1_cons_4;
   logic [WIDTH-1:0]   r_s1_cons_5;
   logic               r_s1_sel_1;
   logic               r_s1_sel_3;
   logic               r_s1_sel_5;
   logic [1:0]         r_s1_sel_2;
   logic [1:0]         r_s1_sel_4;
   logic [1:0]         r_s1_sel_6;
   logic [1:0]         r_s1_sel_7;
   logic [1:0]         r_s1_sel_8;
   logic [1:0]         r_s1_rel;

   logic               w_in_range;
   logic               w_fwd;
   logic [WIDTH-1:0]   w_st_next;
   logic [c_EXT_W-1:0] w_cmp_a;
   logic [c_EXT_W-1:0] w_cmp_b;
   logic               w_cond;
   logic [c_EXT_W-1:0] w_sum;
   logic [2:0]         w_top;
   logic [WIDTH-1:0]   w_res;

   function automatic logic [c_EXT_W-1:0] f_ext(input logic [WIDTH-1:0] v);
      if (SIGNED) return {{2{v[WIDTH-1]}}, v};
      else        return {2'b00, v};
   endfunction

   function automatic logic [WIDTH-1:0] f_mux3(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] p1,
                                               input logic [WIDTH-1:0] p2,
                                               input logic [WIDTH-1:0] c);
      case (sel)
         2'd0:    return p1;
         2'd1:    return p2;
         default: return c;
      endcase
   endfunction

   // Forward the in-flight result when the incoming packet targets the same word.
   always_comb begin
      w_in_range = ({1'b0, in_idx} < c_DEPTH);
      w_fwd      = r_s1_valid && r_s1_in_range && (r_s1_idx == in_idx);
      if (!w_in_range)  w_st_next = c_ZERO;
      else if (w_fwd)   w_st_next = w_res;
      else              w_st_next = r_mem[in_idx];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid    <= 1'b0;
         r_s1_in_range <= 1'b0;
         r_s1_idx      <= '0;
         r_s1_st       <= '0;
         r_s1_pkt_1    <= '0;
         r_s1_pkt_2    <= '0;
         r_s1_cons_1   <= '0;
         r_s1_cons_2   <= '0;
         r_s1_cons_3   <= '0;
         r_s1_cons_4   <= '0;
         r_s1_cons_5   <= '0;
         r_s1_sel_1    <= 1'b0;
         r_s1_sel_3    <= 1'b0;
         r_s1_sel_5    <= 1'b0;
         r_s1_sel_2    <= '0;
         r_s1_sel_4    <= '0;
         r_s1_sel_6    <= '0;
         r_s1_sel_7    <= '0;
         r_s1_sel_8    <= '0;
         r_s1_rel      <= '0;
      end else begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_in_range <= w_in_range;
            r_s1_idx      <= in_idx;
            r_s1_st       <= w_st_next;
            r_s1_pkt_1    <= pkt_1;
            r_s1_pkt_2    <= pkt_2;
            r_s1_cons_1   <= cons_1;
            r_s1_cons_2   <= cons_2;
            r_s1_cons_3   <= cons_3;
            r_s1_cons_4   <= cons_4;
            r_s1_cons_5   <= cons_5;
            r_s1_sel_1    <= sel_1;
            r_s1_sel_3    <= sel_3;
            r_s1_sel_5    <= sel_5;
            r_s1_sel_2    <= sel_2;
            r_s1_sel_4    <= sel_4;
            r_s1_sel_6    <= sel_6;
            r_s1_sel_7    <= sel_7;
            r_s1_sel_8    <= sel_8;
            r_s1_rel      <= rel_opcode;
         end
      end
   end

   // Operands are extended by two bits so a+b-c never overflows before clamping.
   always_comb begin
      w_cmp_a = f_ext(r_s1_sel_1 ? c_ZERO : r_s1_st);
      w_cmp_b = f_ext(f_mux3(r_s1_sel_2, r_s1_pkt_1, r_s1_pkt_2, r_s1_cons_1));
      w_cond  = 1'b0;
      case (r_s1_rel)
         2'd0:    w_cond = (w_cmp_a != w_cmp_b);
         2'd1:    w_cond = ($signed(w_cmp_a) < $signed(w_cmp_b));
         2'd2:    w_cond = ($signed(w_cmp_a) > $signed(w_cmp_b));
         default: w_cond = (w_cmp_a == w_cmp_b);
      endcase

      if (w_cond)
         w_sum = f_ext(r_s1_sel_3 ? c_ZERO : r_s1_st)
               + f_ext(f_mux3(r_s1_sel_4, r_s1_pkt_1, r_s1_pkt_2, r_s1_cons_2))
               - f_ext(f_mux3(r_s1_sel_7, r_s1_pkt_1, r_s1_pkt_2, r_s1_cons_4));
      else
         w_sum = f_ext(r_s1_sel_5 ? c_ZERO : r_s1_st)
               + f_ext(f_mux3(r_s1_sel_6, r_s1_pkt_1, r_s1_pkt_2, r_s1_cons_3))
               - f_ext(f_mux3(r_s1_sel_8, r_s1_pkt_1, r_s1_pkt_2, r_s1_cons_5));

      w_top = w_sum[c_EXT_W-1:WIDTH-1];
      w_res = w_sum[WIDTH-1:0];
      if (SATURATE) begin
         if (SIGNED) begin
            if ((w_top != 3'b000) && (w_top != 3'b111))
               w_res = w_sum[c_EXT_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
         end else begin
            if (w_sum[c_EXT_W-1])  w_res = '0;
            else if (w_sum[WIDTH]) w_res = '1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (r_s1_valid && r_s1_in_range) begin
         r_mem[r_s1_idx] <= w_res;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_idx   <= '0;
         o__read   <= '0;
         o__write  <= '0;
      end else begin
         out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            out_idx  <= r_s1_idx;
            o__read  <= r_s1_st;
            o__write <= w_res;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_stateful_array_atom.sv
`default_nettype none
// Bench for stateful_array_atom: four instances (32-bit unsigned wrap, 32-bit signed,
// 8-bit saturating, 8-bit wrapping) share stimulus and are checked against a model.
module tb_stateful_array_atom;

   typedef struct {
      bit          v;
      logic [3:0]  idx;
      logic [31:0] p1, p2, c1, c2, c3, c4, c5;
      logic        s1, s3, s5;
      logic [1:0]  s2, s4, s6, s7, s8, rel;
   } stim_t;

   typedef struct {
      logic [3:0]       idx;
      logic [3:0][31:0] rd;
      logic [3:0][31:0] wr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [3:0]  in_idx;
   logic [31:0] pkt_1, pkt_2, cons_1, cons_2, cons_3, cons_4, cons_5;
   logic        sel_1, sel_3, sel_5;
   logic [1:0]  sel_2, sel_4, sel_6, sel_7, sel_8, rel_opcode;

   logic [3:0]       ov;
   logic [3:0][3:0]  oi;
   logic [3:0][31:0] rd, wr;
   logic [7:0]       rd2, wr2, rd3, wr3;

   assign rd[2] = {24'h0, rd2};
   assign wr[2] = {24'h0, wr2};
   assign rd[3] = {24'h0, rd3};
   assign wr[3] = {24'h0, wr3};

   logic [31:0] mm [4][16];
   exp_t        sb[$];
   stim_t       cfg;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   stateful_array_atom u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_idx(in_idx),
      .pkt_1(pkt_1), .pkt_2(pkt_2), .cons_1(cons_1), .cons_2(cons_2), .cons_3(cons_3),
      .cons_4(cons_4), .cons_5(cons_5), .sel_1(sel_1), .sel_3(sel_3), .sel_5(sel_5),
      .sel_2(sel_2), .sel_4(sel_4), .sel_6(sel_6), .sel_7(sel_7), .sel_8(sel_8),
      .rel_opcode(rel_opcode), .out_valid(ov[0]), .out_idx(oi[0]),
      .o__read(rd[0]), .o__write(wr[0]));

   stateful_array_atom #(.SIGNED(1'b1)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_idx(in_idx),
      .pkt_1(pkt_1), .pkt_2(pkt_2), .cons_1(cons_1), .cons_2(cons_2), .cons_3(cons_3),
      .cons_4(cons_4), .cons_5(cons_5), .sel_1(sel_1), .sel_3(sel_3), .sel_5(sel_5),
      .sel_2(sel_2), .sel_4(sel_4), .sel_6(sel_6), .sel_7(sel_7), .sel_8(sel_8),
      .rel_opcode(rel_opcode), .out_valid(ov[1]), .out_idx(oi[1]),
      .o__read(rd[1]), .o__write(wr[1]));

   stateful_array_atom #(.WIDTH(8), .SATURATE(1'b1)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_idx(in_idx),
      .pkt_1(pkt_1[7:0]), .pkt_2(pkt_2[7:0]), .cons_1(cons_1[7:0]), .cons_2(cons_2[7:0]),
      .cons_3(cons_3[7:0]), .cons_4(cons_4[7:0]), .cons_5(cons_5[7:0]),
      .sel_1(sel_1), .sel_3(sel_3), .sel_5(sel_5),
      .sel_2(sel_2), .sel_4(sel_4), .sel_6(sel_6), .sel_7(sel_7), .sel_8(sel_8),
      .rel_opcode(rel_opcode), .out_valid(ov[2]), .out_idx(oi[2]),
      .o__read(rd2), .o__write(wr2));

   stateful_array_atom #(.WIDTH(8)) u3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_idx(in_idx),
      .pkt_1(pkt_1[7:0]), .pkt_2(pkt_2[7:0]), .cons_1(cons_1[7:0]), .cons_2(cons_2[7:0]),
      .cons_3(cons_3[7:0]), .cons_4(cons_4[7:0]), .cons_5(cons_5[7:0]),
      .sel_1(sel_1), .sel_3(sel_3), .sel_5(sel_5),
      .sel_2(sel_2), .sel_4(sel_4), .sel_6(sel_6), .sel_7(sel_7), .sel_8(sel_8),
      .rel_opcode(rel_opcode), .out_valid(ov[3]), .out_idx(oi[3]),
      .o__read(rd3), .o__write(wr3));

   // Interpret a field at width w as a mathematical integer.
   function automatic longint sx(input logic [31:0] v, input int w, input bit sgn);
      longint u;
      u = (w == 8) ? longint'({56'h0, v[7:0]}) : longint'({32'h0, v});
      if (sgn && u[w-1]) u = u - (longint'(1) << w);
      return u;
   endfunction

   function automatic logic [31:0] pick(input logic [1:0] s, input stim_t t,
                                        input logic [31:0] c);
      return (s == 2'd0) ? t.p1 : (s == 2'd1) ? t.p2 : c;
   endfunction

   function automatic logic [31:0] model(input int k, input logic [31:0] st, input stim_t t);
      int     w;
      bit     sgn, sat, cond;
      longint a, b, r, lo, hi;
      w   = (k >= 2) ? 8 : 32;
      sgn = (k == 1);
      sat = (k == 2);
      a = sx(t.s1 ? 32'h0 : st, w, sgn);
      b = sx(pick(t.s2, t, t.c1), w, sgn);
      case (t.rel)
         2'd0:    cond = (a != b);
         2'd1:    cond = (a < b);
         2'd2:    cond = (a > b);
         default: cond = (a == b);
      endcase
      if (cond) r = sx(t.s3 ? 32'h0 : st, w, sgn) + sx(pick(t.s4, t, t.c2), w, sgn)
                  - sx(pick(t.s7, t, t.c4), w, sgn);
      else      r = sx(t.s5 ? 32'h0 : st, w, sgn) + sx(pick(t.s6, t, t.c3), w, sgn)
                  - sx(pick(t.s8, t, t.c5), w, sgn);
      if (sat) begin
         lo = sgn ? -(longint'(1) << (w - 1)) : 64'sd0;
         hi = sgn ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
         if (r < lo) r = lo;
         if (r > hi) r = hi;
      end
      return (w == 8) ? {24'h0, r[7:0]} : r[31:0];
   endfunction

   // Applies one cycle of inputs; a valid packet updates the model and queues its result.
   task automatic drive(input stim_t t);
      exp_t e;
      in_valid = t.v;   in_idx = t.idx;
      pkt_1 = t.p1;     pkt_2 = t.p2;
      cons_1 = t.c1; cons_2 = t.c2; cons_3 = t.c3; cons_4 = t.c4; cons_5 = t.c5;
      sel_1 = t.s1; sel_3 = t.s3; sel_5 = t.s5;
      sel_2 = t.s2; sel_4 = t.s4; sel_6 = t.s6; sel_7 = t.s7; sel_8 = t.s8;
      rel_opcode = t.rel;
      if (t.v) begin
         e.idx = t.idx;
         for (int k = 0; k < 4; k++) begin
            e.rd[k] = mm[k][t.idx];
            e.wr[k] = model(k, mm[k][t.idx], t);
            mm[k][t.idx] = e.wr[k];
         end
         sb.push_back(e);
      end
   endtask

   function automatic stim_t idle();
      stim_t t;
      t   = cfg;
      t.v = 1'b0;
      return t;
   endfunction

   function automatic stim_t pk(input logic [3:0] idx, input logic [31:0] p1,
                                input logic [31:0] p2);
      stim_t t;
      t = cfg; t.v = 1'b1; t.idx = idx; t.p1 = p1; t.p2 = p2;
      return t;
   endfunction

   // Readback config: condition always true, result = state + 0 - 0.
   function automatic stim_t ident_cfg();
      stim_t t;
      t = '{v: 1'b0, idx: 4'd0, p1: 32'd0, p2: 32'd0, c1: 32'd0, c2: 32'd0, c3: 32'd0,
            c4: 32'd0, c5: 32'd0, s1: 1'b0, s3: 1'b0, s5: 1'b0, s2: 2'd2, s4: 2'd2,
            s6: 2'd2, s7: 2'd2, s8: 2'd2, rel: 2'd3};
      return t;
   endfunction

   task automatic clear_model();
      for (int k = 0; k < 4; k++)
         for (int i = 0; i < 16; i++) mm[k][i] = 32'h0;
      sb.delete();
   endtask

   task automatic test_reset();
      stim_t q[$];
      exp_t  e;
      cfg = ident_cfg();
      clear_model();
      rst = 1'b1;
      drive(idle());
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if ({ov[k], oi[k], rd[k], wr[k]} !== 69'h0) begin
            n_bad++;
            $display("FAIL reset_idle u%0d: got v=%b idx=%0d read=%h write=%h, want all 0",
                     k, ov[k], oi[k], rd[k], wr[k]);
         end
      end
      for (int i = 0; i < 16; i++) q.push_back(pk(4'(i), 32'd0, 32'd0));
      for (int c = 0; c < q.size() + 3; c++) begin
         @(posedge clk); #1;
         if (ov != 4'b0000) begin
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL readback: got out_valid=%b, want no output", ov);
            end else begin
               e = sb.pop_front();
               for (int k = 0; k < 4; k++) begin
                  n_cmp++;
                  if ({ov[k], oi[k], rd[k], wr[k]} !== {1'b1, e.idx, e.rd[k], e.wr[k]}) begin
                     n_bad++;
                     $display("FAIL readback u%0d: got v=%b idx=%0d rd=%h wr=%h, want idx=%0d rd=%h wr=%h",
                              k, ov[k], oi[k], rd[k], wr[k], e.idx, e.rd[k], e.wr[k]);
                  end
               end
            end
         end
         drive((c < q.size()) ? q[c] : idle());
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL readback_drain: got %0d outputs missing, want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic run_main(input string nm, input stim_t q[$]);
      exp_t e;
      for (int c = 0; c < q.size() + 3; c++) begin
         @(posedge clk); #1;
         if (ov != 4'b0000) begin
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL %s: got out_valid=%b, want no output", nm, ov);
            end else begin
               e = sb.pop_front();
               for (int k = 0; k < 4; k++) begin
                  n_cmp++;
                  if ({ov[k], oi[k], rd[k], wr[k]} !== {1'b1, e.idx, e.rd[k], e.wr[k]}) begin
                     n_bad++;
                     $display("FAIL %s u%0d: got v=%b idx=%0d rd=%h wr=%h, want idx=%0d rd=%h wr=%h",
                              nm, k, ov[k], oi[k], rd[k], wr[k], e.idx, e.rd[k], e.wr[k]);
                  end
               end
            end
         end
         drive((c < q.size()) ? q[c] : idle());
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL %s_drain: got %0d outputs missing, want 0", nm, sb.size());
         sb.delete();
      end
   endtask

   function automatic stim_t plan_cfg();
      stim_t t;
      t = ident_cfg();
      t.s1 = 1'b0; t.s2 = 2'd0; t.rel = 2'd1;
      t.s3 = 1'b0; t.s4 = 2'd1; t.s7 = 2'd2; t.c4 = 32'd3;
      t.s5 = 1'b0; t.s6 = 2'd2; t.c3 = 32'd0; t.s8 = 2'd2; t.c5 = 32'd1;
      return t;
   endfunction

   task automatic test_back_to_back();
      stim_t q[$];
      cfg = plan_cfg();
      q.push_back(pk(4'd2, 32'd5, 32'd10));
      q.push_back(pk(4'd2, 32'd5, 32'd10));
      run_main("back_to_back", q);
   endtask

   task automatic test_gap_interleave();
      stim_t q[$];
      cfg = plan_cfg();
      q.push_back(pk(4'd5, 32'd5, 32'd10));
      q.push_back(idle());
      q.push_back(pk(4'd5, 32'd5, 32'd10));
      q.push_back(pk(4'd3, 32'd5, 32'd10));
      q.push_back(pk(4'd11, 32'd5, 32'd10));
      q.push_back(pk(4'd3, 32'd5, 32'd10));
      q.push_back(pk(4'd11, 32'd5, 32'd10));
      run_main("gap_interleave", q);
   endtask

   // Condition forced true (0 == cons_1 = 0); true branch does the arithmetic.
   task automatic test_saturation();
      stim_t q[$];
      stim_t t;
      cfg = ident_cfg();
      cfg.s1 = 1'b1;
      t = pk(4'd7, 32'd250, 32'd0); t.s3 = 1'b1; t.s4 = 2'd0; q.push_back(t);
      t = pk(4'd7, 32'd0, 32'd10);  t.s3 = 1'b0; t.s4 = 2'd1; q.push_back(t);
      t = pk(4'd7, 32'd2, 32'd0);   t.s3 = 1'b1; t.s4 = 2'd0; q.push_back(t);
      t = pk(4'd7, 32'd5, 32'd0);   t.s3 = 1'b0; t.s4 = 2'd2; t.s7 = 2'd0; q.push_back(t);
      run_main("saturation", q);
   endtask

   task automatic test_signed();
      stim_t q[$];
      stim_t t;
      cfg = ident_cfg();
      t = pk(4'd8, 32'hFFFF_FFFF, 32'd0); t.s1 = 1'b1; t.s3 = 1'b1; t.s4 = 2'd0;
      q.push_back(t);
      t = pk(4'd8, 32'd1, 32'd0);
      t.s2 = 2'd0; t.rel = 2'd1; t.c2 = 32'd100; t.c3 = 32'd200;
      q.push_back(t);
      run_main("signed_cmp", q);
   endtask

   task automatic test_async_reset();
      stim_t q[$];
      stim_t t;
      cfg = ident_cfg();
      cfg.s1 = 1'b1; cfg.s3 = 1'b1; cfg.s4 = 2'd0;
      @(posedge clk); #1;
      drive(pk(4'd9, 32'h55, 32'd0));
      @(posedge clk); #1;
      drive(pk(4'd10, 32'h66, 32'd0));
      #3 rst = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if ({ov[k], oi[k], rd[k], wr[k]} !== 69'h0) begin
            n_bad++;
            $display("FAIL async_reset u%0d: got v=%b idx=%0d read=%h write=%h, want all 0",
                     k, ov[k], oi[k], rd[k], wr[k]);
         end
      end
      clear_model();
      cfg = ident_cfg();
      @(posedge clk); #1;
      drive(idle());
      #2 rst = 1'b0;
      q.push_back(pk(4'd9, 32'd0, 32'd0));
      q.push_back(pk(4'd10, 32'd0, 32'd0));
      run_main("post_reset", q);
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_gap_interleave();
      test_saturation();
      test_signed();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/stateful_array_atom.md
Name: stateful_array_atom

Overview:
- Parametrised successor to the single-register conditional add/subtract stateful atom.
- Holds DEPTH independent state words of WIDTH bits, selected per packet by an index field.
- Two-stage pipeline: read-modify-write with same-index forwarding, so back-to-back packets to one index see each other's updates.
- Optional signed compare and saturating arithmetic.
- Sits in a pipeline stage of the packet-transaction datapath; one packet accepted per cycle.

Parameters:
- WIDTH, 32, width of packet fields, constants and state words.
- DEPTH, 16, number of state words (>=2).
- IDX_W, $clog2(DEPTH), index width.
- SIGNED, 0, 1 = relational ops and saturation treat operands as two's complement; 0 = unsigned.
- SATURATE, 0, 1 = update result clamps to the representable range; 0 = modulo 2^WIDTH wrap.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  packet present this cycle.
- in_idx  in  IDX_W  state word selector.
- pkt_1, pkt_2  in  WIDTH  packet fields.
- cons_1..cons_5  in  WIDTH  configuration constants.
- sel_1, sel_3, sel_5  in  1  state-or-zero select: 0 = state, 1 = 0.
- sel_2, sel_4, sel_6, sel_7, sel_8  in  2  operand select: 0 = pkt_1, 1 = pkt_2, 2 or 3 = constant.
- rel_opcode  in  2  compare op: 0 = !=, 1 = <, 2 = >, 3 = ==.
- out_valid  out  1  result valid.
- out_idx  out  IDX_W  index of result.
- o__read  out  WIDTH  state value before the update.
- o__write  out  WIDTH  new state value.

Behaviour:
- Reset (async, any time): all DEPTH state words = 0; both stage valids = 0; out_valid = 0, out_idx = 0, o__read = 0, o__write = 0. An in-flight packet is discarded and no write occurs.
- S1, the edge after in_valid=1:
  - registers idx, pkt_*, cons_*, sel_*, rel_opcode;
  - registers state[in_idx] as the operand, except when S2 is valid with the same idx in that cycle. In that case the S2 result (o__write next value) is captured instead, which is the forwarding path.
- S2, combinational on the S1 registers:
  - cond = rel_op(mux2(st,0,sel_1), mux3(pkt_1,pkt_2,cons_1,sel_2), rel_opcode).
  - cond=1: res = mux2(st,0,sel_3) + mux3(..,cons_2,sel_4) - mux3(..,cons_4,sel_7).
  - cond=0: res = mux2(st,0,sel_5) + mux3(..,cons_3,sel_6) - mux3(..,cons_5,sel_8).
  - mux3 uses cons for sel 2 and 3.
- Arithmetic:
  - computed at WIDTH+2 bits, sign- or zero-extended per SIGNED.
  - SATURATE=1: clamp to [0, 2^WIDTH-1] unsigned, or [-2^(WIDTH-1), 2^(WIDTH-1)-1] signed.
  - SATURATE=0: truncate to WIDTH.
- Edge after S2 valid:
  - state[idx] <= res;
  - out_valid=1, out_idx=idx, o__read=st, o__write=res.
- Latency: 2 cycles from in_valid edge to out_valid. Throughput: 1 per cycle.
- Outputs are registered. When no S2 packet is present, out_valid=0 and o__read, o__write, out_idx hold their last values.
- Hazards:
  - Back-to-back same idx: the forwarded value is used, never the stale array word.
  - Gap of 1+ idle cycles: the array already holds the update.
  - Different idx: no interaction.
- Bubbles (in_valid=0) propagate; nothing is written for them.
- in_idx >= DEPTH (non-power-of-2 DEPTH): packet passes through with st=0 and no write. out_valid still asserts.

Test Plan:
- Reset then idle 5 cycles -> out_valid=0, all outputs 0. Read back idx 0..DEPTH-1 via sel_1=0, rel_opcode=3, cons_1=0 packets -> o__read=0 each.
- Config sel_1=0, sel_2=0, rel_opcode=1, sel_3=0, sel_4=1, sel_7=2, cons_4=3, sel_5=0, sel_6=2, cons_3=0, sel_8=2, cons_5=1. idx=2, pkt_1=5, pkt_2=10, applied in two consecutive cycles:
  - first packet -> o__read=0, o__write=7;
  - second packet (forwarded, 7<5 false) -> o__read=7, o__write=6.
- Same two packets with one idle cycle between, and then interleaved with idx=3 -> identical results per index, no cross-index corruption.
- SATURATE=1, SIGNED=0, WIDTH=8: state 250, add pkt_2=10 -> o__write=255. State 2, subtract 5 -> 0. With SATURATE=0: 4 and 253.
- SIGNED=1, rel_opcode=1: state 0xFFFF_FFFF (-1) < pkt_1=1 -> true branch taken. With SIGNED=0 -> false branch.
- Assert rst while packets sit in S1 and S2 -> outputs zero immediately, the targeted words remain 0, and the first packet after reset sees st=0.
